// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel path: streams one WIDTH x HEIGHT frame out of pixel RAM in
// raster order, clears the window generator at frame start, tags each pixel with the
// centre coordinate it completes, flushes the pipeline, then pulses done.
module sobel_frame_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HEIGHT   = 8,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned ADDR_W   = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              win_rst,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              res_valid,
  output logic [15:0]       res_x,
  output logic [15:0]       res_y,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam logic [15:0] XMax   = 16'(WIDTH - 1);
  localparam logic [15:0] YMax   = 16'(HEIGHT - 1);
  localparam logic [15:0] DrainN = 16'(PIPE_LAT);

  typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [15:0]         x_q, y_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         drain_q;
  logic [15:0]         frame_cnt_q;
  logic                rd;
  logic                drain_pulse;
  logic                last_rd;
  logic                pv_d;
  logic                pix_valid_q;
  logic                pix_src_q;

  // Tag of the pixel being read this cycle
  logic                tag_v;
  logic [15:0]         tag_x, tag_y;

  logic                sr_v [PIPE_LAT];
  logic [15:0]         sr_x [PIPE_LAT];
  logic [15:0]         sr_y [PIPE_LAT];
  logic                res_valid_q;
  logic [15:0]         res_x_q, res_y_q;

  // Next-state and strobe decode
  always_comb begin
    state_d     = state_q;
    rd          = 1'b0;
    drain_pulse = 1'b0;
    win_rst     = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        win_rst = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (!hold) begin
          rd = 1'b1;
          if (x_q == XMax && y_q == YMax) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave only once the final flush pulse is on pix_valid
        if (drain_q == DrainN) state_d = StDone;
        else if (!hold) drain_pulse = 1'b1;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign last_rd = rd && (x_q == XMax) && (y_q == YMax);
  assign pv_d    = rd | drain_pulse;
  assign tag_v   = rd && (x_q >= 16'd2) && (y_q >= 16'd2);
  assign tag_x   = tag_v ? x_q - 16'd1 : 16'd0;
  assign tag_y   = tag_v ? y_q - 16'd1 : 16'd0;

  // State, raster position and drain/frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      addr_q      <= '0;
      drain_q     <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StClear) begin
        x_q     <= 16'd0;
        y_q     <= 16'd0;
        addr_q  <= '0;
        drain_q <= 16'd0;
      end else if (last_rd) begin
        // Park the address at 0 so idle outputs stay quiet
        x_q    <= 16'd0;
        y_q    <= 16'd0;
        addr_q <= '0;
      end else if (rd) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (x_q == XMax) begin
          x_q <= 16'd0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
      end
      if (drain_pulse) drain_q <= drain_q + 16'd1;
      if (state_q == StDone) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Pixel strobe follows the read by the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_src_q   <= 1'b0;
    end else begin
      pix_valid_q <= pv_d;
      pix_src_q   <= rd;
    end
  end

  // Tag shift register; advances only on pipeline steps, tail registered into res_*
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        sr_v[i] <= 1'b0;
        sr_x[i] <= 16'd0;
        sr_y[i] <= 16'd0;
      end
      res_valid_q <= 1'b0;
      res_x_q     <= 16'd0;
      res_y_q     <= 16'd0;
    end else begin
      res_valid_q <= 1'b0;
      if (pv_d) begin
        sr_v[0] <= tag_v;
        sr_x[0] <= tag_x;
        sr_y[0] <= tag_y;
        for (int i = 1; i < int'(PIPE_LAT); i++) begin
          sr_v[i] <= sr_v[i-1];
          sr_x[i] <= sr_x[i-1];
          sr_y[i] <= sr_y[i-1];
        end
        res_valid_q <= sr_v[PIPE_LAT-1];
        if (sr_v[PIPE_LAT-1]) begin
          res_x_q <= sr_x[PIPE_LAT-1];
          res_y_q <= sr_y[PIPE_LAT-1];
        end
      end
    end
  end

  assign mem_rd_en = rd;
  assign mem_addr  = addr_q;
  assign pix_valid = pix_valid_q;
  // Drain pulses carry zero data
  assign pix_data  = pix_src_q ? mem_rd_data : 8'h00;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: a 4x4 and a 3x3 instance, each backed by a
// synchronous RAM model, with per-frame event logs checked against hand-derived cycles.
module tb_sobel_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, start4, start3, sel;

  logic        rd4, wr4, pv4, rv4, busy4, done4;
  logic [3:0]  addr4;
  logic [7:0]  rdata4, pd4;
  logic [15:0] rx4, ry4, fc4;
  logic        rd3, wr3, pv3, rv3, busy3, done3;
  logic [3:0]  addr3;
  logic [7:0]  rdata3, pd3;
  logic [15:0] rx3, ry3, fc3;

  sobel_frame_ctrl #(.WIDTH(4), .HEIGHT(4), .PIPE_LAT(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .hold(hold),
    .mem_rd_en(rd4), .mem_addr(addr4), .mem_rd_data(rdata4),
    .win_rst(wr4), .pix_data(pd4), .pix_valid(pv4),
    .res_valid(rv4), .res_x(rx4), .res_y(ry4),
    .busy(busy4), .done(done4), .frame_cnt(fc4)
  );

  sobel_frame_ctrl #(.WIDTH(3), .HEIGHT(3), .PIPE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .hold(hold),
    .mem_rd_en(rd3), .mem_addr(addr3), .mem_rd_data(rdata3),
    .win_rst(wr3), .pix_data(pd3), .pix_valid(pv3),
    .res_valid(rv3), .res_x(rx3), .res_y(ry3),
    .busy(busy3), .done(done3), .frame_cnt(fc3)
  );

  function automatic logic [7:0] mem_f(input logic [3:0] a);
    return {4'b0, a} * 8'd5 + 8'd3;
  endfunction

  // Synchronous RAM models: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (rd4) rdata4 <= mem_f(addr4);
    if (rd3) rdata3 <= mem_f(addr3);
  end

  logic        o_rd, o_wr, o_pv, o_rv, o_busy, o_done;
  logic [3:0]  o_addr;
  logic [7:0]  o_pd;
  logic [15:0] o_rx, o_ry, o_fc;
  assign o_rd   = sel ? rd3   : rd4;
  assign o_wr   = sel ? wr3   : wr4;
  assign o_pv   = sel ? pv3   : pv4;
  assign o_rv   = sel ? rv3   : rv4;
  assign o_busy = sel ? busy3 : busy4;
  assign o_done = sel ? done3 : done4;
  assign o_addr = sel ? addr3 : addr4;
  assign o_pd   = sel ? pd3   : pd4;
  assign o_rx   = sel ? rx3   : rx4;
  assign o_ry   = sel ? ry3   : ry4;
  assign o_fc   = sel ? fc3   : fc4;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Per-frame event log
  int wr_cnt, wr_first, rd_cnt, rd_first, rd_last, addr_err, hold_rd;
  int pv_cnt, pv_first, pv_last, pix_err, clash, busy_cnt, done_cnt, done_c, res_cnt;
  int res_c [8];
  int res_xs [8];
  int res_ys [8];

  // Runs one frame from start at c0; optional hold window, stray start, mid-frame reset
  task automatic run_frame(input int hs, input int he, input int restart_c, input int rst_c);
    int         exp_addr;
    logic       prev_rd;
    logic [3:0] prev_addr;
    logic [7:0] exp_pd;
    exp_addr = 0; prev_rd = 1'b0; prev_addr = 4'd0;
    wr_cnt = 0; wr_first = -1; rd_cnt = 0; rd_first = -1; rd_last = -1; addr_err = 0;
    hold_rd = 0; pv_cnt = 0; pv_first = -1; pv_last = -1; pix_err = 0; clash = 0;
    busy_cnt = 0; done_cnt = 0; done_c = -1; res_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      start4 = !sel && (c == 0 || c == restart_c);
      start3 = sel && (c == 0 || c == restart_c);
      hold   = (c >= hs && c <= he);
      rst    = (c == rst_c);
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_rd_en", o_rd, 0);
        check_eq("rst_pix_valid", o_pv, 0);
        check_eq("rst_res_valid", o_rv, 0);
        check_eq("rst_frame_cnt", o_fc, 0);
        check_eq("rst_addr", o_addr, 0);
        check_eq("rst_res_xy", {o_rx, o_ry}, 0);
        break;
      end
      if (o_wr) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = c;
      end
      if (o_rd) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        if (o_addr != 4'(exp_addr)) addr_err++;
        exp_addr++;
        if (c >= hs && c <= he) hold_rd++;
      end
      if (o_pv) begin
        pv_cnt++;
        if (pv_first < 0) pv_first = c;
        pv_last = c;
        exp_pd = prev_rd ? mem_f(prev_addr) : 8'h00;
        if (o_pd != exp_pd) pix_err++;
        if (o_wr) clash++;
      end
      prev_rd   = o_rd;
      prev_addr = o_addr;
      if (o_busy) busy_cnt++;
      if (o_rv) begin
        if (res_cnt < 8) begin
          res_c[res_cnt]  = c;
          res_xs[res_cnt] = int'(o_rx);
          res_ys[res_cnt] = int'(o_ry);
        end
        res_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 1) break;
    end
    start4 = 1'b0; start3 = 1'b0; hold = 1'b0; rst = 1'b0;
  endtask

  task automatic check_4x4_results(input string tag);
    check_eq({tag, "_res_cnt"}, res_cnt, 4);
    check_eq({tag, "_res0"}, res_xs[0] * 100 + res_ys[0], 101);
    check_eq({tag, "_res1"}, res_xs[1] * 100 + res_ys[1], 201);
    check_eq({tag, "_res2"}, res_xs[2] * 100 + res_ys[2], 102);
    check_eq({tag, "_res3"}, res_xs[3] * 100 + res_ys[3], 202);
  endtask

  initial begin
    int stray;
    sel = 1'b0; rst = 1'b1; start4 = 1'b0; start3 = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", busy4, 0);
    check_eq("reset_done", done4, 0);
    check_eq("reset_frame_cnt", fc4, 0);
    check_eq("reset_rd_en", rd4, 0);
    check_eq("reset_pix_valid", pv4, 0);
    check_eq("reset_win_rst", wr4, 0);
    check_eq("reset_res", {rv4, rx4, ry4}, 0);
    check_eq("reset_addr", addr4, 0);

    // Plain 4x4 frame
    run_frame(-1, -2, -1, -1);
    check_eq("a_win_rst_cnt", wr_cnt, 1);
    check_eq("a_win_rst_cyc", wr_first, 1);
    check_eq("a_rd_first", rd_first, 2);
    check_eq("a_rd_last", rd_last, 17);
    check_eq("a_rd_cnt", rd_cnt, 16);
    check_eq("a_addr_err", addr_err, 0);
    check_eq("a_pv_first", pv_first, 3);
    check_eq("a_pv_last", pv_last, 21);
    check_eq("a_pv_cnt", pv_cnt, 19);
    check_eq("a_pix_err", pix_err, 0);
    check_eq("a_clash", clash, 0);
    check_eq("a_done_cyc", done_c, 22);
    check_eq("a_done_cnt", done_cnt, 1);
    check_eq("a_busy_cnt", busy_cnt, 22);
    check_eq("a_res_cyc", res_c[0] * 1000000 + res_c[1] * 10000 + res_c[2] * 100 + res_c[3],
             16172021);
    check_4x4_results("a");
    check_eq("a_frame_cnt", o_fc, 1);

    // Hold during c5..c8
    run_frame(5, 8, -1, -1);
    check_eq("b_hold_rd", hold_rd, 0);
    check_eq("b_rd_cnt", rd_cnt, 16);
    check_eq("b_addr_err", addr_err, 0);
    check_eq("b_rd_last", rd_last, 21);
    check_eq("b_pix_err", pix_err, 0);
    check_eq("b_done_cyc", done_c, 26);
    check_4x4_results("b");
    check_eq("b_frame_cnt", o_fc, 2);

    // Stray start mid-stream is ignored
    run_frame(-1, -2, 8, -1);
    check_eq("c_done_cnt", done_cnt, 1);
    check_eq("c_done_cyc", done_c, 22);
    check_eq("c_rd_cnt", rd_cnt, 16);
    check_eq("c_frame_cnt", o_fc, 3);

    // Reset at c10 aborts; outputs checked at c11 inside the run
    run_frame(-1, -2, -1, 10);
    check_eq("d_rd_before_rst", rd_cnt, 9);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_rd || o_done || o_busy) stray++;
    end
    check_eq("d_quiet_after_rst", stray, 0);

    // Clean frame after the abort
    run_frame(-1, -2, -1, -1);
    check_eq("e_win_rst_cnt", wr_cnt, 1);
    check_eq("e_rd_first", rd_first, 2);
    check_eq("e_addr_err", addr_err, 0);
    check_eq("e_rd_cnt", rd_cnt, 16);
    check_4x4_results("e");
    check_eq("e_frame_cnt", o_fc, 1);

    // Back-to-back frame
    run_frame(-1, -2, -1, -1);
    check_eq("f_win_rst_cnt", wr_cnt, 1);
    check_eq("f_done_cyc", done_c, 22);
    check_4x4_results("f");
    check_eq("f_frame_cnt", o_fc, 2);

    // Minimum 3x3 frame
    sel = 1'b1;
    run_frame(-1, -2, -1, -1);
    check_eq("g_rd_cnt", rd_cnt, 9);
    check_eq("g_rd_last", rd_last, 10);
    check_eq("g_addr_err", addr_err, 0);
    check_eq("g_pv_cnt", pv_cnt, 12);
    check_eq("g_pv_last", pv_last, 14);
    check_eq("g_pix_err", pix_err, 0);
    check_eq("g_done_cyc", done_c, 15);
    check_eq("g_res_cnt", res_cnt, 1);
    check_eq("g_res_xy", res_xs[0] * 100 + res_ys[0], 101);
    check_eq("g_res_cyc", res_c[0], 14);
    check_eq("g_frame_cnt", o_fc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
